taxi_stats_sched: RTL

TAXI_STATS_SCHED -- requirements
Module: taxi_stats_sched

---
 rtl/taxi_stats_pkg.sv | 23 ++
 rtl/taxi_axis_if.sv | 39 +++
 rtl/taxi_stats_rr_arb.sv | 72 +++++++
 rtl/taxi_stats_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_stats_pkg
//  Description : Shared sizing helpers for the statistics scheduler: the
//                round-robin pointer width and the flush slot length.
//  Revision    : 1.0 - initial release
// ============================================================================

package taxi_stats_pkg;

    // Width of a pointer that indexes PORTS sources (never narrower than 1 bit)
    function automatic int rr_ptr_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Cycles allotted to each collector within one flush round, at least 1
    function automatic int slot_len(input int period, input int ports);
        return ((period / ports) > 1) ? (period / ports) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/taxi_axis_if.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_axis_if
//  Description : AXI4-Stream bundle used between the statistics collectors,
//                the scheduler and the downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================

interface taxi_axis_if #(
    parameter int   DATA_W  = 8,
    parameter int   KEEP_W  = (DATA_W + 7) / 8,
    parameter int   ID_W    = 8,
    parameter int   DEST_W  = 8,
    parameter logic USER_EN = 1'b0,
    parameter int   USER_W  = 1
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/taxi_stats_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_stats_rr_arb
//  Description : Round-robin arbiter. Grants the first requester at or after
//                the pointer (cyclically); the pointer moves past the winner
//                only when the caller strobes i_advance.
//  Revision    : 1.0 - initial release
// ============================================================================

module taxi_stats_rr_arb
    import taxi_stats_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int PTR_W = rr_ptr_w(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] i_req,
    input  logic             i_advance,
    output logic             o_grant_valid,
    output logic [PORTS-1:0] o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PORTS - 1);

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    int               w_cand;

    // Priority search: walk candidates from the far end back to the pointer so the
    // last match written is the nearest requester at or after the pointer.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        o_grant       = '0;
        w_cand        = 0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            w_cand = int'(rr_ptr_q) + i;
            if (w_cand >= PORTS) begin
                w_cand = w_cand - PORTS;
            end
            if (i_req[PTR_W'(w_cand)]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = PTR_W'(w_cand);
            end
        end
        if (o_grant_valid) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    // Next pointer: one past the winner when its beat is taken, otherwise hold
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (i_advance && o_grant_valid) begin
            rr_ptr_d = (o_grant_idx == LAST_IDX) ? '0 : o_grant_idx + PTR_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/taxi_stats_sched.sv
`default_nettype none
// ============================================================================
//  Module      : taxi_stats_sched
//  Description : Merges single-beat statistics streams from PORTS collectors
//                into one stream through a round-robin arbiter and a single
//                output register, and schedules staggered per-collector flush
//                pulses every UPDATE_PERIOD cycles (or on demand via update).
//                Optional macro TAXI_STATS_SCHED_TID_OFFSET_EN adds the
//                source port index, shifted by ID_SHIFT, to the output tid.
//  Revision    : 1.0 - initial release
// ============================================================================

module taxi_stats_sched
    import taxi_stats_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int UPDATE_PERIOD = 1024,
    parameter int ID_SHIFT      = 8
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axis_if.snk         s_axis_stat [PORTS],
    taxi_axis_if.src         m_axis_stat,
    output logic [PORTS-1:0] update_out,
    output logic [PORTS-1:0] gate_out,
    input  logic [PORTS-1:0] gate_in,
    input  logic             update,
    output logic             busy
);

    localparam int DATA_W = m_axis_stat.DATA_W;
    localparam int M_ID_W = m_axis_stat.ID_W;
    localparam int S_ID_W = s_axis_stat[0].ID_W;
    localparam int USER_W = m_axis_stat.USER_W;
    localparam int PTR_W  = rr_ptr_w(PORTS);
    localparam int SLOT   = slot_len(UPDATE_PERIOD, PORTS);
    localparam int CNT_W  = $clog2(SLOT + 1);

    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PORTS - 1);

    // ------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------
    if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
        $fatal(0, "taxi_stats_sched: PORTS must be within 2..16 (instance %m)");
    end

    // ------------------------------------------------------------------
    // Flatten the source interfaces into vectors/arrays
    // ------------------------------------------------------------------
    logic [PORTS-1:0]  w_req;
    logic [PORTS-1:0]  w_tready;
    logic [DATA_W-1:0] w_tdata [PORTS];
    logic [S_ID_W-1:0] w_tid   [PORTS];
    logic [USER_W-1:0] w_tuser [PORTS];

    for (genvar n = 0; n < PORTS; n++) begin : g_port
        if (s_axis_stat[n].DATA_W != DATA_W) begin : g_bad_data_w
            $fatal(0, "taxi_stats_sched: s/m DATA_W mismatch (instance %m)");
        end
        if (s_axis_stat[n].USER_EN != m_axis_stat.USER_EN || s_axis_stat[n].USER_W != USER_W) begin : g_bad_user
            $fatal(0, "taxi_stats_sched: s/m USER_EN/USER_W mismatch (instance %m)");
        end
        if (s_axis_stat[n].ID_W != S_ID_W) begin : g_bad_id_w
            $fatal(0, "taxi_stats_sched: all sources must share ID_W (instance %m)");
        end

        assign w_req[n]             = s_axis_stat[n].tvalid;
        assign w_tdata[n]           = s_axis_stat[n].tdata;
        assign w_tid[n]             = s_axis_stat[n].tid;
        assign w_tuser[n]           = s_axis_stat[n].tuser;
        assign s_axis_stat[n].tready = w_tready[n];
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             w_grant_valid;
    logic [PORTS-1:0] w_grant;
    logic [PTR_W-1:0] w_grant_idx;
    logic             w_accept;

    logic              m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0] m_tdata_q,  m_tdata_d;
    logic [M_ID_W-1:0] m_tid_q,    m_tid_d;
    logic [USER_W-1:0] m_tuser_q,  m_tuser_d;

    taxi_stats_rr_arb #(
        .PORTS (PORTS)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .i_advance     (w_accept),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx)
    );

    // A beat moves in when the register is free or emptying this cycle; nothing
    // is taken while reset is asserted so no handshake straddles reset.
    assign w_accept = !rst && w_grant_valid && (!m_tvalid_q || m_axis_stat.tready);
    assign w_tready = w_accept ? w_grant : '0;

    // ------------------------------------------------------------------
    // Output tid formation
    // ------------------------------------------------------------------
    logic [M_ID_W-1:0] w_sel_tid;

`ifdef TAXI_STATS_SCHED_TID_OFFSET_EN
    if (M_ID_W < ID_SHIFT + $clog2(PORTS)) begin : g_bad_m_id_w
        $fatal(0, "taxi_stats_sched: m ID_W too narrow for the port offset (instance %m)");
    end
    if (S_ID_W > ID_SHIFT) begin : g_bad_s_id_w
        $fatal(0, "taxi_stats_sched: s ID_W overlaps the port offset field (instance %m)");
    end
    assign w_sel_tid = M_ID_W'(w_tid[w_grant_idx]) + (M_ID_W'(w_grant_idx) << ID_SHIFT);
`else
    if (ID_SHIFT < 0) begin : g_bad_shift
        $fatal(0, "taxi_stats_sched: ID_SHIFT must be non-negative (instance %m)");
    end
    assign w_sel_tid = M_ID_W'(w_tid[w_grant_idx]);
`endif

    // Output register next state: drain on tready, refill on accept
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tid_d    = m_tid_q;
        m_tuser_d  = m_tuser_q;
        if (m_axis_stat.tready) begin
            m_tvalid_d = 1'b0;
        end
        if (w_accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = w_tdata[w_grant_idx];
            m_tid_d    = w_sel_tid;
            m_tuser_d  = w_tuser[w_grant_idx];
        end
    end

    // Output register; a held beat is dropped by reset
    always_ff @(posedge clk) begin
        m_tdata_q <= m_tdata_d;
        m_tid_q   <= m_tid_d;
        m_tuser_q <= m_tuser_d;
        if (rst) begin
            m_tvalid_q <= 1'b0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_axis_stat.tvalid = m_tvalid_q && !rst;
    assign m_axis_stat.tdata  = m_tdata_q;
    assign m_axis_stat.tid    = m_tid_q;
    assign m_axis_stat.tuser  = m_tuser_q;
    assign m_axis_stat.tkeep  = '1;
    assign m_axis_stat.tlast  = 1'b1;
    assign m_axis_stat.tdest  = '0;

    assign busy = !rst && (m_tvalid_q || (|w_req));

    // ------------------------------------------------------------------
    // Flush scheduler
    // ------------------------------------------------------------------
    // cnt_q holds the cycles left in the current slot, including this one.
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [PTR_W-1:0] slot_idx_q, slot_idx_d;
    logic [PORTS-1:0] w_flush;

    // Slot timing: a forced round restarts at slot 0 and absorbs any coincident
    // scheduled pulse, so only one all-ones pulse is emitted.
    always_comb begin
        cnt_d      = cnt_q - CNT_ONE;
        slot_idx_d = slot_idx_q;
        w_flush    = '0;
        if (update) begin
            w_flush    = '1;
            cnt_d      = SLOT_CNT;
            slot_idx_d = '0;
        end else if (cnt_q == CNT_ONE) begin
            w_flush[slot_idx_q] = 1'b1;
            cnt_d               = SLOT_CNT;
            slot_idx_d          = (slot_idx_q == LAST_IDX) ? '0 : slot_idx_q + PTR_W'(1);
        end
    end

    // Scheduler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= SLOT_CNT;
            slot_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            slot_idx_q <= slot_idx_d;
        end
    end

    assign update_out = rst ? '0 : w_flush;

    // ------------------------------------------------------------------
    // Gate pass-through
    // ------------------------------------------------------------------
    logic [PORTS-1:0] gate_out_q, gate_out_d;

    // Gate request is simply retimed by one cycle
    always_comb begin
        gate_out_d = gate_in;
    end

    // Gate register
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_out_q <= '0;
        end else begin
            gate_out_q <= gate_out_d;
        end
    end

    assign gate_out = gate_out_q;

endmodule

`default_nettype wire
